// File: rtl/vga_digit_writer_if.sv
// vga_digit_writer_if: valid/ready digit-write channel from the RTC controller.
interface vga_digit_writer_if;
  logic       valid;
  logic       ready;
  logic [4:0] field;
  logic [3:0] bcd;
  modport master (output valid, field, bcd, input ready);
  modport slave (input valid, field, bcd, output ready);
endinterface

// File: rtl/vga_digit_writer.sv
// vga_digit_writer: shadow/active BCD digit banks, copied once per frame at vsync so the renderer never sees a torn update.
module vga_digit_writer #(
  parameter int         NUM_DIGITS = 18,
  parameter logic       VS_ACTIVE  = 1'b0,
  parameter logic [3:0] RESET_BCD  = 4'd0
) (
  input  logic               clk,
  input  logic               rst_n,
  vga_digit_writer_if.slave  wr,
  input  logic               vs_i,
  input  logic [4:0]         rd_field_i,
  output logic [3:0]         rd_bcd_o,
  output logic               commit_o,
  output logic               err_o
);
  localparam logic [4:0] LAST = 5'(NUM_DIGITS - 1);
  typedef enum logic {ACCEPT, COPY} state_e;
  state_e     state_q, state_d;
  logic [4:0] idx_q, idx_d;
  logic       dirty_q, dirty_d;
  logic       vs_q, ready_q, err_q;
  logic [3:0] rd_q;
  logic [3:0] shadow_q [NUM_DIGITS];
  logic [3:0] active_q [NUM_DIGITS];
  logic       xfer, ok, vs_edge;
  assign xfer     = wr.valid & ready_q;
  assign ok       = (wr.field <= LAST) & (wr.bcd <= 4'd9);
  assign vs_edge  = (vs_i == VS_ACTIVE) & (vs_q != VS_ACTIVE);
  assign commit_o = (state_q == COPY) & (idx_q == LAST);
  assign wr.ready = ready_q;
  assign rd_bcd_o = rd_q;
  assign err_o    = err_q;
  // dirty_d already folds in this cycle's write, so a write on the vsync edge joins the copy
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    dirty_d = dirty_q | (xfer & ok);
    if (state_q == ACCEPT) begin
      if (vs_edge & dirty_d) begin
        state_d = COPY;
        idx_d   = 5'd0;
        dirty_d = 1'b0;
      end
    end else begin
      idx_d   = idx_q + 5'd1;
      state_d = (idx_q == LAST) ? ACCEPT : COPY;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ACCEPT;
      idx_q   <= 5'd0;
      dirty_q <= 1'b0;
      vs_q    <= ~VS_ACTIVE;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      rd_q    <= RESET_BCD;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        shadow_q[i] <= RESET_BCD;
        active_q[i] <= RESET_BCD;
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      dirty_q <= dirty_d;
      vs_q    <= vs_i;
      ready_q <= (state_d == ACCEPT);
      err_q   <= err_q | (xfer & ~ok);
      rd_q    <= (rd_field_i <= LAST) ? active_q[rd_field_i] : 4'hF;
      if (xfer & ok) shadow_q[wr.field] <= wr.bcd;
      if (state_q == COPY) active_q[idx_q] <= shadow_q[idx_q];
    end
  end
endmodule

// File: tb/tb_vga_digit_writer.sv
// tb_vga_digit_writer: directed spec scenarios plus random traffic against a frame-level digit bank model.
module tb_vga_digit_writer;
  localparam int N = 18;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       vs = 1'b1;
  logic [4:0] rd_field = 5'd0;
  logic [3:0] rd_bcd;
  logic       commit, err;
  int         vectors = 0;
  int         miscompares = 0;
  vga_digit_writer_if wr ();
  vga_digit_writer dut (
    .clk(clk), .rst_n(rst_n), .wr(wr), .vs_i(vs),
    .rd_field_i(rd_field), .rd_bcd_o(rd_bcd), .commit_o(commit), .err_o(err)
  );
  always #5 clk = ~clk;
  // Reference: whole-bank snapshot taken at the frame edge, revealed one slot per cycle
  logic [3:0] m_shadow [N];
  logic [3:0] m_active [N];
  logic [3:0] m_snap [N];
  logic [3:0] m_rd;
  bit         m_dirty, m_err, m_busy, m_ready, m_vs_prev;
  int         m_cnt;
  task automatic check(string tag, logic [7:0] got, logic [7:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic [3:0] visible(int k);
    return (m_busy && k < m_cnt) ? m_snap[k] : m_active[k];
  endfunction
  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      m_shadow[k] = 4'd0;
      m_active[k] = 4'd0;
      m_snap[k]   = 4'd0;
    end
    {m_dirty, m_err, m_busy, m_ready} = 4'b0;
    m_vs_prev = 1'b1;
    m_cnt     = 0;
    m_rd      = 4'd0;
  endtask
  task automatic check_outputs();
    check("ready", {7'd0, wr.ready}, {7'd0, m_ready});
    check("commit", {7'd0, commit}, {7'd0, m_busy && m_cnt == N - 1});
    check("err", {7'd0, err}, {7'd0, m_err});
    check("rd_bcd", {4'd0, rd_bcd}, {4'd0, m_rd});
  endtask
  task automatic step(bit v, int f, int b, bit s, int rf);
    bit vs_edge;
    check_outputs();
    wr.valid = v;
    wr.field = 5'(f);
    wr.bcd   = 4'(b);
    vs       = s;
    rd_field = 5'(rf);
    @(posedge clk);
    m_rd = (rf < N) ? visible(rf) : 4'hF;
    vs_edge = !s && m_vs_prev;
    m_vs_prev = s;
    if (!m_busy) begin
      if (v && m_ready) begin
        if (f < N && b <= 9) begin
          m_shadow[f] = 4'(b);
          m_dirty = 1'b1;
        end else m_err = 1'b1;
      end
      if (vs_edge && m_dirty) begin
        m_busy  = 1'b1;
        m_cnt   = 0;
        m_snap  = m_shadow;
        m_dirty = 1'b0;
      end
    end else begin
      m_cnt++;
      if (m_cnt == N) begin
        m_active = m_snap;
        m_busy   = 1'b0;
      end
    end
    m_ready = !m_busy;
    @(negedge clk);
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    wr.valid = 1'b0;
    vs = 1'b1;
    #1;
    model_reset();
    check("rst_ready", {7'd0, wr.ready}, 8'd0);
    check("rst_commit", {7'd0, commit}, 8'd0);
    check("rst_err", {7'd0, err}, 8'd0);
    check("rst_rd_bcd", {4'd0, rd_bcd}, 8'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask
  task automatic idle(int n, bit s, int rf);
    for (int k = 0; k < n; k++) step(1'b0, 0, 0, s, rf);
  endtask
  task automatic sweep();
    for (int k = 0; k <= N + 2; k++) step(1'b0, 0, 0, 1'b1, k);
  endtask
  initial begin
    wr.valid = 1'b0;
    wr.field = 5'd0;
    wr.bcd   = 4'd0;
    @(negedge clk);
    do_reset();
    sweep();
    // slot 7 update only becomes visible after the next frame edge
    step(1'b1, 7, 5, 1'b1, 7);
    idle(5, 1'b1, 7);
    idle(25, 1'b0, 7);
    idle(3, 1'b1, 7);
    // rejected writes flag ERR and leave nothing to copy
    step(1'b1, 20, 3, 1'b1, 2);
    step(1'b1, 2, 10, 1'b1, 2);
    idle(3, 1'b1, 2);
    idle(25, 1'b0, 2);
    idle(3, 1'b1, 2);
    // write landing on the vsync edge itself
    step(1'b1, 0, 9, 1'b0, 0);
    idle(25, 1'b0, 0);
    idle(3, 1'b1, 0);
    // writer stalls through a copy, with a second vsync edge inside it
    step(1'b1, 3, 1, 1'b1, 3);
    step(1'b0, 0, 0, 1'b0, 3);
    for (int k = 0; m_busy && k < 40; k++) step(1'b1, 4, 6, (k % 6) < 3, 4);
    step(1'b1, 4, 6, 1'b1, 4);
    idle(3, 1'b1, 4);
    idle(25, 1'b0, 4);
    idle(3, 1'b1, 4);
    // reset in the middle of a copy
    step(1'b1, 11, 8, 1'b1, 11);
    step(1'b0, 0, 0, 1'b0, 11);
    for (int k = 0; !(m_busy && m_cnt == 9) && k < 40; k++) step(1'b0, 0, 0, 1'b0, k % N);
    check("copy_reached_idx9", {7'd0, m_busy && m_cnt == 9}, 8'd1);
    do_reset();
    sweep();
    for (int seg = 0; seg < 3; seg++) begin
      do_reset();
      for (int t = 0; t < 800; t++) begin
        int f, b;
        f = ($urandom_range(0, 39) == 0) ? $urandom_range(18, 31) : $urandom_range(0, N - 1);
        b = ($urandom_range(0, 39) == 0) ? $urandom_range(10, 15) : $urandom_range(0, 9);
        step($urandom_range(0, 1) == 1, f, b, (t % 45) < 40, $urandom_range(0, 20));
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
